// File: rtl/uba_intack_pkg.sv
// Shared types and constants for the UBA interrupt-acknowledge responder.
// Bit numbering is little-endian throughout: PDP-10 bit n of a 36-bit word is bit 35-n here.
package uba_intack_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StDone,
    StRelease
  } state_e;

  localparam int unsigned WordW          = 36;
  localparam int unsigned CntW           = 8;
  localparam int unsigned DefaultTimeout = 63;

  // PDP-10 bits 14..17 hold the adapter number, bits 20..35 the device vector.
  localparam int unsigned UbaNumLsb = 18;
  localparam int unsigned UbaNumW   = 4;
  localparam int unsigned VectLsb   = 0;
  localparam int unsigned VectW     = 16;

  function automatic logic [WordW-1:0] vector_word(input logic [UbaNumW-1:0] ubanum,
                                                   input logic [VectW-1:0]   vect);
    logic [WordW-1:0] w;
    w = '0;
    w[UbaNumLsb +: UbaNumW] = ubanum;
    w[VectLsb +: VectW]     = vect;
    return w;
  endfunction

endpackage

// File: rtl/uba_intack_if.sv
// CPU-side acknowledge handshake plus device request/grant/vector lines.
// The responder uses the slave modport; the CPU/device side drives through master.
interface uba_intack_if;
  import uba_intack_pkg::*;

  logic             busREQI;
  logic [2:0]       busPI;
  logic [2:0]       statPIH;
  logic [2:0]       statPIL;
  logic [7:4]       devINTR;
  logic [7:4]       devACKO;
  logic             devVECTV;
  logic [15:0]      devVECT;
  logic             busACKO;
  logic [WordW-1:0] busDATAO;
  logic             statTIMO;

  modport slave (
    input  busREQI,
    input  busPI,
    input  statPIH,
    input  statPIL,
    input  devINTR,
    input  devVECTV,
    input  devVECT,
    output devACKO,
    output busACKO,
    output busDATAO,
    output statTIMO
  );

  modport master (
    output busREQI,
    output busPI,
    output statPIH,
    output statPIL,
    output devINTR,
    output devVECTV,
    output devVECT,
    input  devACKO,
    input  busACKO,
    input  busDATAO,
    input  statTIMO
  );

endinterface

// File: rtl/uba_intack_arb.sv
// Priority encoder: picks the winning bus request for the PI level being acknowledged.
// The BR7/BR6 group beats BR5/BR4 when both sit on the same level.
module uba_intack_arb (
  input  logic [7:4] dev_intr_i,
  input  logic [2:0] stat_pih_i,
  input  logic [2:0] stat_pil_i,
  input  logic [2:0] bus_pi_i,
  output logic [7:4] grant_o,
  output logic       match_o
);

  logic hi_match;
  logic lo_match;
  logic pi_valid;

  always_comb begin
    pi_valid = (bus_pi_i != 3'd0);
    hi_match = (dev_intr_i[7] | dev_intr_i[6]) & (stat_pih_i == bus_pi_i) & pi_valid;
    lo_match = (dev_intr_i[5] | dev_intr_i[4]) & (stat_pil_i == bus_pi_i) & pi_valid;

    grant_o = '0;
    if (hi_match) begin
      grant_o = dev_intr_i[7] ? 4'b1000 : 4'b0100;
    end else if (lo_match) begin
      grant_o = dev_intr_i[5] ? 4'b0010 : 4'b0001;
    end
    match_o = hi_match | lo_match;
  end

endmodule

// File: rtl/uba_intack.sv
// UBA interrupt-acknowledge responder: grants the winning device, collects its vector
// and returns it to the CPU with a one-cycle acknowledge, or a zero word on timeout.
module uba_intack
  import uba_intack_pkg::*;
#(
  parameter logic [3:0]  UBANUM  = 4'd1,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input logic          clk,
  input logic          rst,
  uba_intack_if.slave  bus_io
);

  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:4]       devack_q, devack_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic [WordW-1:0] data_q, data_d;
  logic             timo_q, timo_d;

  logic [7:4]       arb_grant;
  logic             arb_match;

  uba_intack_arb u_arb (
    .dev_intr_i (bus_io.devINTR),
    .stat_pih_i (bus_io.statPIH),
    .stat_pil_i (bus_io.statPIL),
    .bus_pi_i   (bus_io.busPI),
    .grant_o    (arb_grant),
    .match_o    (arb_match)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      devack_q <= '0;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      data_q   <= '0;
      timo_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      devack_q <= devack_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      data_q   <= data_d;
      timo_q   <= timo_d;
    end
  end

  // Acknowledge, data word and timeout flag default low so they live for DONE only.
  always_comb begin
    state_d  = state_q;
    devack_d = devack_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    data_d   = '0;
    timo_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.busREQI && arb_match) begin
          devack_d = arb_grant;
          cnt_d    = '0;
          state_d  = StGrant;
        end
      end
      StGrant: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_io.devVECTV) begin
          data_d   = vector_word(UBANUM, bus_io.devVECT);
          ack_d    = 1'b1;
          devack_d = '0;
          state_d  = StDone;
        end else if (cnt_q == CntLast) begin
          ack_d    = 1'b1;
          timo_d   = 1'b1;
          devack_d = '0;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StRelease;
      end
      StRelease: begin
        // A request still held from the last cycle must not be acknowledged twice.
        if (!bus_io.busREQI) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d  = StIdle;
        devack_d = '0;
      end
    endcase
  end

  always_comb begin
    bus_io.devACKO  = devack_q;
    bus_io.busACKO  = ack_q;
    bus_io.busDATAO = data_q;
    bus_io.statTIMO = timo_q;
  end

  a_grant_onehot0 : assert property (@(posedge clk) $onehot0(devack_q));

  a_grant_stable : assert property (@(posedge clk) disable iff (!rst)
      (state_q == StGrant && state_d == StGrant) |=> $stable(devack_q));

endmodule

// File: tb/tb_uba_intack.sv
// Randomized transaction-level bench for uba_intack against a behavioural reference model.
module tb_uba_intack;
  import uba_intack_pkg::*;

  localparam logic [3:0]  Ubanum = 4'd9;
  localparam int unsigned Tmo    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  uba_intack_if bus ();

  uba_intack #(
    .UBANUM  (Ubanum),
    .TIMEOUT (Tmo)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scan requests from highest to lowest; each BR listens on its group's PI level.
  function automatic logic [3:0] ref_grant(input logic [2:0] pih, input logic [2:0] pil,
                                           input logic [2:0] pi, input logic [3:0] intr);
    logic [2:0] lvl;
    for (int br = 7; br >= 4; br--) begin
      lvl = (br >= 6) ? pih : pil;
      if (intr[br-4] && pi != 3'd0 && lvl == pi) return 4'b0001 << (br - 4);
    end
    return 4'b0000;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_grant"}, 64'(bus.devACKO), 64'd0);
    check({tag, "_ack"}, 64'(bus.busACKO), 64'd0);
    check({tag, "_timo"}, 64'(bus.statTIMO), 64'd0);
  endtask

  // One CPU acknowledge cycle. Vector is presented d cycles into GRANT (d>=Tmo: never in time).
  task automatic run_txn(input logic [2:0] pih, input logic [2:0] pil, input logic [2:0] pi,
                         input logic [3:0] intr, input int unsigned d, input logic [15:0] vect,
                         input int unsigned hold, input bit drop_intr);
    logic [3:0]  g;
    logic [35:0] exp_word;
    int unsigned e;
    bit          to;
    g = ref_grant(pih, pil, pi, intr);
    bus.statPIH = pih;
    bus.statPIL = pil;
    bus.busPI   = pi;
    bus.devINTR = intr;
    bus.busREQI = 1'b1;
    if (g == 4'b0000) begin
      for (int i = 0; i < 4; i++) begin
        tick();
        check_quiet("nomatch");
      end
      bus.busREQI = 1'b0;
      tick();
      tick();
    end else begin
      to       = (d > Tmo - 1);
      e        = to ? 1 + Tmo : 2 + d;
      exp_word = to ? 36'd0 : {14'd0, Ubanum, 2'd0, vect};
      for (int n = 1; n <= int'(e) + 1; n++) begin
        tick();
        if (n < int'(e)) begin
          check("grant", 64'(bus.devACKO), 64'(g));
          check("ack_early", 64'(bus.busACKO), 64'd0);
          check("timo_early", 64'(bus.statTIMO), 64'd0);
        end else if (n == int'(e)) begin
          check("ack", 64'(bus.busACKO), 64'd1);
          check("data", 64'(bus.busDATAO), 64'(exp_word));
          check("timo", 64'(bus.statTIMO), 64'(to));
          check("grant_drop", 64'(bus.devACKO), 64'd0);
        end else begin
          check("ack_clr", 64'(bus.busACKO), 64'd0);
          check("data_clr", 64'(bus.busDATAO), 64'd0);
          check("timo_clr", 64'(bus.statTIMO), 64'd0);
        end
        bus.devVECTV = (n == 1 + int'(d));
        bus.devVECT  = (n == 1 + int'(d)) ? vect : 16'($urandom);
        if (drop_intr && n == 1) bus.devINTR = 4'b0000;
      end
      bus.devVECTV = 1'b0;
      bus.devINTR  = intr;
      for (int h = 0; h < int'(hold); h++) begin
        tick();
        check_quiet("held");
      end
      bus.busREQI = 1'b0;
      tick();
      tick();
      check_quiet("released");
    end
  endtask

  initial begin
    logic [2:0] pi, pih, pil;
    bus.busREQI  = 1'b0;
    bus.busPI    = 3'd0;
    bus.statPIH  = 3'd0;
    bus.statPIL  = 3'd0;
    bus.devINTR  = 4'b0000;
    bus.devVECTV = 1'b0;
    bus.devVECT  = 16'd0;

    rst = 1'b0;
    repeat (3) tick();
    check_quiet("reset");
    check("reset_data", 64'(bus.busDATAO), 64'd0);
    rst = 1'b1;
    tick();

    run_txn(3'd3, 3'd0, 3'd3, 4'b1000, 0, 16'o000224, 2, 1'b0);
    run_txn(3'd5, 3'd5, 3'd5, 4'b0101, 3, 16'hbeef, 1, 1'b0);
    run_txn(3'd2, 3'd6, 3'd2, 4'b0010, 0, 16'h1234, 0, 1'b0);
    run_txn(3'd4, 3'd1, 3'd1, 4'b0011, Tmo + 2, 16'h5555, 0, 1'b0);
    run_txn(3'd7, 3'd2, 3'd7, 4'b0100, Tmo - 1, 16'h0f0f, 10, 1'b0);
    run_txn(3'd6, 3'd6, 3'd6, 4'b0001, 2, 16'hcafe, 3, 1'b1);
    run_txn(3'd0, 3'd0, 3'd0, 4'b1111, 0, 16'h0001, 0, 1'b0);

    // Reset during GRANT drops the grant; a late vector is then ignored.
    bus.statPIH = 3'd4;
    bus.statPIL = 3'd2;
    bus.busPI   = 3'd2;
    bus.devINTR = 4'b0010;
    bus.busREQI = 1'b1;
    tick();
    check("rstmid_grant", 64'(bus.devACKO), 64'b0010);
    tick();
    rst         = 1'b0;
    bus.busREQI = 1'b0;
    tick();
    check_quiet("rstmid");
    rst          = 1'b1;
    bus.devVECTV = 1'b1;
    bus.devVECT  = 16'h7777;
    tick();
    check_quiet("rstmid_vec");
    bus.devVECTV = 1'b0;
    tick();
    check_quiet("rstmid_after");

    for (int t = 0; t < 60; t++) begin
      pi  = ($urandom_range(0, 7) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      pih = ($urandom_range(0, 1) == 1) ? pi : 3'($urandom);
      pil = ($urandom_range(0, 1) == 1) ? pi : 3'($urandom);
      run_txn(pih, pil, pi, 4'($urandom), $urandom_range(0, Tmo + 2), 16'($urandom),
              $urandom_range(0, 10), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uba_intack.md
Name: uba_intack

Overview:
- Responder side of the UBA interrupt path. Requests reach the CPU as PI levels.
- When the CPU runs an interrupt-acknowledge ("who are you") cycle for a PI level, this block does the following:
  - picks the winning device request group;
  - issues a one-hot bus grant to the device;
  - captures the device's 16-bit vector;
  - returns the vector word to the CPU with a one-cycle acknowledge.
- Sits in the UBA between the IO-bridge bus interface and the device interrupt/grant lines.

Parameters:
- UBANUM, 4'd1, adapter number placed in the returned vector word.
- TIMEOUT, 63, cycles to wait in GRANT for the device vector before aborting (range 1..255).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset
- busREQI  input  1  CPU interrupt-acknowledge request, level, held until busACKO is seen
- busPI  input  3  [15:17] PI level being acknowledged (1..7; 0 never acknowledged)
- statPIH  input  3  [0:2] PI level assigned to BR7/BR6
- statPIL  input  3  [0:2] PI level assigned to BR5/BR4
- devINTR  input  4  [7:4] device bus requests BR7..BR4
- devACKO  output  4  [7:4] one-hot bus grant BG7..BG4
- devVECTV  input  1  device vector valid
- devVECT  input  16  [0:15] device vector
- busACKO  output  1  one-cycle acknowledge to CPU
- busDATAO  output  36  [0:35] vector word, valid only while busACKO=1
- statTIMO  output  1  one-cycle pulse on vector timeout

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE, devACKO=0, busACKO=0, busDATAO=0, statTIMO=0, timeout counter=0. Reset mid-operation drops the grant at that edge; no acknowledge is produced.
- Group match:
  - hiMatch = (devINTR[7]|devINTR[6]) & (statPIH==busPI) & (busPI!=0).
  - loMatch = (devINTR[5]|devINTR[4]) & (statPIL==busPI) & (busPI!=0).
- Arbitration (combinational, sampled only in IDLE):
  - If hiMatch, the winner is BR7 if set, otherwise BR6.
  - Otherwise, if loMatch, the winner is BR5 if set, otherwise BR4.
  - If statPIH==statPIL and both groups are requesting, the high group wins.
- States:
  - IDLE:
    - If busREQI & (hiMatch|loMatch): register the winning one-hot into devACKO, clear the counter, go to GRANT. Grant is visible 1 cycle after busREQI is sampled.
    - If busREQI with no match: stay in IDLE with no ack. The CPU bus timeout handles it.
  - GRANT: devACKO held constant; the counter increments each cycle.
    - If devVECTV is sampled high: busDATAO <= {14'b0, UBANUM, 2'b0, devVECT}, busACKO <= 1, devACKO <= 0, go to DONE.
    - Else if counter == TIMEOUT-1: busDATAO <= 0, busACKO <= 1, statTIMO <= 1, devACKO <= 0, go to DONE.
    - If devVECTV and the timeout coincide, the vector wins and statTIMO stays 0.
    - If the device drops devINTR during GRANT, the grant is still held until vector or timeout.
  - DONE: busACKO, busDATAO and statTIMO are high/valid for exactly this one cycle, then cleared. Go to RELEASE.
  - RELEASE: wait for busREQI=0, then go to IDLE. Prevents a held request from being acknowledged twice.
- Latency:
  - busREQI sampled to devACKO: 1 cycle.
  - devVECTV sampled to busACKO: 1 cycle.
  - Minimum request-to-ack latency: 2 cycles after busREQI is sampled.
- devACKO is always one-hot or zero and never changes while in GRANT.
- Counter width is 8 bits; no wrap is possible because TIMEOUT≤255.

Decomposition:
- Package uba_intack_pkg:
  - state enum (IDLE, GRANT, DONE, RELEASE);
  - vector word field positions (UBANUM at [14:17], vector at [20:35]);
  - default TIMEOUT constant.
- Sub-module uba_intack_arb: combinational priority encoder (devINTR, statPIH, statPIL, busPI → one-hot grant, match). Unit-testable on its own.

Test Plan:
- Vector return: statPIH=3, devINTR=4'b1000, busREQI with busPI=3 → devACKO=4'b1000 next cycle; devVECTV with devVECT=16'o000224 → busACKO one cycle with busDATAO[20:35]=16'o000224 and [14:17]=UBANUM.
- High-group wins on shared level: statPIH=statPIL=5, devINTR=4'b0101, busPI=5 → devACKO=4'b0100.
- No match: statPIH=2, statPIL=6, devINTR=4'b0010, busPI=2 → state stays IDLE, devACKO=0, busACKO=0.
- Timeout: TIMEOUT=8, valid grant, devVECTV never asserted → after 8 GRANT cycles, busACKO=1, busDATAO=0 and statTIMO=1 for one cycle; devACKO=0.
- Held request: busREQI held high 10 cycles after busACKO → no second grant; busREQI low then high again → new grant.
- Reset mid-operation: rst=0 during GRANT → next edge devACKO=0, busACKO=0, state IDLE; a devVECTV arriving afterwards is ignored.
